// File: rtl/nac_instr_if.sv
// Instruction hand-off bus between the NAC assembler and the execute stage.
interface nac_instr_if #(
  parameter int unsigned MAX_ARGS = 4
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [7:0]                instr_opcode;
  logic [7:0]                instr_argc;
  logic [16*MAX_ARGS-1:0]    instr_args;
  logic [31:0]               instr_pc;

  modport master (
    output instr_valid, instr_opcode, instr_argc, instr_args, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_argc, instr_args, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/nac_instr_assembler.sv
// NAC instruction assembler: pulls bytes from the fetcher, builds
// opcode/argc/operand instructions and owns redirect/flush sequencing.
module nac_instr_assembler #(
  parameter int unsigned MAX_ARGS = 4,
  parameter int unsigned ARGC_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_byte_req,
  input  logic [7:0]  fetch_byte_data,
  input  logic        fetch_byte_valid,
  input  logic        fetch_busy,
  output logic        fetch_flush,
  output logic [31:0] fetch_start_addr,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  nac_instr_if.master instr,
  output logic        err_argc
);

  localparam int unsigned IDX_W  = $clog2(2 * MAX_ARGS);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned ARGS_W = 16 * MAX_ARGS;

  typedef enum logic [2:0] {
    S_HALT, S_OPC, S_ARGC, S_ARGS, S_OUT, S_FLUSH, S_ERR
  } state_e;

  state_e              state_q;
  logic [31:0]         pc_q;
  logic                pend_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ARGS_W-1:0]   args_q;
  logic [7:0]          opcode_q;
  logic [ARGC_W-1:0]   argc_q;
  logic [31:0]         ipc_q;
  logic                valid_q;
  logic                flush_q;
  logic [31:0]         start_q;
  logic                err_q;

  logic                fetching_c;
  logic                accept_c;
  logic                last_c;
  logic [CNT_W-1:0]    need_c;
  logic [CNT_W-1:0]    remain_c;

  // Request only what the current field still needs, counting the byte in flight.
  always_comb begin
    fetching_c     = (state_q == S_OPC) || (state_q == S_ARGC) || (state_q == S_ARGS);
    need_c         = {argc_q[IDX_W-1:0], 1'b0};
    remain_c       = (state_q == S_ARGS) ? (need_c - {1'b0, idx_q}) : CNT_W'(1);
    last_c         = (({1'b0, idx_q} + CNT_W'(1)) == need_c);
    accept_c       = fetch_byte_valid && pend_q && !redirect && fetching_c;
    fetch_byte_req = fetching_c && !redirect && (remain_c > CNT_W'(pend_q));
  end

  // Assembly state machine; redirect overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HALT;
      pc_q     <= '0;
      pend_q   <= 1'b0;
      idx_q    <= '0;
      args_q   <= '0;
      opcode_q <= '0;
      argc_q   <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      start_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      pend_q  <= fetch_byte_req && !fetch_busy;
      flush_q <= 1'b0;
      if (redirect) begin
        state_q <= S_FLUSH;
        flush_q <= 1'b1;
        start_q <= redirect_addr;
        pc_q    <= redirect_addr;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          S_FLUSH: state_q <= S_OPC;
          S_OPC: begin
            if (accept_c) begin
              opcode_q <= fetch_byte_data;
              ipc_q    <= pc_q;
              pc_q     <= pc_q + 32'd1;
              state_q  <= S_ARGC;
            end
          end
          S_ARGC: begin
            if (accept_c) begin
              argc_q <= fetch_byte_data;
              pc_q   <= pc_q + 32'd1;
              args_q <= '0;
              idx_q  <= '0;
              if (fetch_byte_data > ARGC_W'(MAX_ARGS)) begin
                err_q   <= 1'b1;
                state_q <= S_ERR;
              end else if (fetch_byte_data == '0) begin
                valid_q <= 1'b1;
                state_q <= S_OUT;
              end else begin
                state_q <= S_ARGS;
              end
            end
          end
          S_ARGS: begin
            if (accept_c) begin
              args_q[{idx_q, 3'b000} +: 8] <= fetch_byte_data;
              pc_q  <= pc_q + 32'd1;
              idx_q <= idx_q + IDX_W'(1);
              if (last_c) begin
                valid_q <= 1'b1;
                state_q <= S_OUT;
              end
            end
          end
          S_OUT: begin
            if (instr.instr_ready) begin
              valid_q <= 1'b0;
              state_q <= S_OPC;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fetch_flush        = flush_q;
  assign fetch_start_addr   = start_q;
  assign err_argc           = err_q;
  assign instr.instr_valid  = valid_q;
  assign instr.instr_opcode = opcode_q;
  assign instr.instr_argc   = argc_q;
  assign instr.instr_args   = args_q;
  assign instr.instr_pc     = ipc_q;

endmodule

// File: tb/tb_nac_instr_assembler.sv
// Bench for nac_instr_assembler: byte-memory fetcher model, instruction
// decoder model over the same memory, and directed scenarios.
module tb_nac_instr_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_byte_req;
  logic [7:0]  fetch_byte_data = 8'h00;
  logic        fetch_byte_valid = 1'b0;
  logic        fetch_busy;
  logic        fetch_flush;
  logic [31:0] fetch_start_addr;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        err_argc;

  always #5 clk = ~clk;

  nac_instr_if #(.MAX_ARGS(4)) bus ();

  nac_instr_assembler #(.MAX_ARGS(4), .ARGC_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_byte_req   (fetch_byte_req),
    .fetch_byte_data  (fetch_byte_data),
    .fetch_byte_valid (fetch_byte_valid),
    .fetch_busy       (fetch_busy),
    .fetch_flush      (fetch_flush),
    .fetch_start_addr (fetch_start_addr),
    .redirect         (redirect),
    .redirect_addr    (redirect_addr),
    .instr            (bus),
    .err_argc         (err_argc)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:4095];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // Fetcher: a granted request returns the next memory byte one cycle later.
  bit          grant_seen = 1'b0;
  bit          flush_seen = 1'b0;
  bit          stray      = 1'b0;
  logic [31:0] start_seen = '0;
  logic [31:0] faddr      = '0;
  int          grants     = 0;

  always @(negedge clk) begin
    grant_seen = rst_n && fetch_byte_req && !fetch_busy;
    flush_seen = fetch_flush;
    start_seen = fetch_start_addr;
  end

  always @(posedge clk) begin
    #1;
    if (flush_seen) faddr = start_seen;
    fetch_byte_valid = grant_seen || stray;
    fetch_byte_data  = grant_seen ? rd(faddr) : 8'hEE;
    if (grant_seen) begin
      faddr  = faddr + 32'd1;
      grants = grants + 1;
    end
  end

  // Per-cycle model: flush follows redirect, and any presented instruction
  // must be the decode of memory at the model's program counter.
  bit          exp_flush = 1'b0;
  logic [31:0] exp_start = '0;
  logic [31:0] model_pc  = '0;

  always @(negedge clk) begin
    logic [7:0]  e_argc;
    logic [63:0] e_args;
    if (rst_n) begin
      chk("flush_pulse", 64'(fetch_flush), 64'(exp_flush));
      if (exp_flush) begin
        chk("flush_addr", 64'(fetch_start_addr), 64'(exp_start));
        chk("valid_in_flush", 64'(bus.instr_valid), 64'd0);
      end
      if (redirect || bus.instr_valid || exp_flush)
        chk("req_when_idle", 64'(fetch_byte_req), 64'd0);
      if (bus.instr_valid) begin
        e_argc = rd(model_pc + 32'd1);
        if (e_argc > 8'd4) begin
          chk("unexpected_instr", 64'(bus.instr_valid), 64'd0);
        end else begin
          e_args = '0;
          for (int i = 0; i < int'(e_argc); i++)
            e_args[16*i +: 16] = {rd(model_pc + 32'(3 + 2*i)), rd(model_pc + 32'(2 + 2*i))};
          chk("m_opcode", 64'(bus.instr_opcode), 64'(rd(model_pc)));
          chk("m_argc",   64'(bus.instr_argc),   64'(e_argc));
          chk("m_args",   bus.instr_args,        e_args);
          chk("m_pc",     64'(bus.instr_pc),     64'(model_pc));
          if (bus.instr_ready && !redirect)
            model_pc = model_pc + 32'd2 + 32'(2 * int'(e_argc));
        end
      end
      exp_flush = redirect;
      exp_start = redirect_addr;
      if (redirect) model_pc = redirect_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect_addr = a;
    redirect      = 1'b1;
    tick();
    redirect      = 1'b0;
  endtask

  task automatic wait_valid(input string name, input bit toggle);
    int n = 0;
    do begin
      tick();
      if (toggle) fetch_busy = ~fetch_busy;
      n++;
    end while (!bus.instr_valid && n < 300);
    chk(name, 64'(bus.instr_valid), 64'd1);
  endtask

  task automatic chk_instr(input string name, input logic [7:0] opc, input logic [7:0] argc,
                           input logic [63:0] args, input logic [31:0] pc);
    chk({name, "_opcode"}, 64'(bus.instr_opcode), 64'(opc));
    chk({name, "_argc"},   64'(bus.instr_argc),   64'(argc));
    chk({name, "_args"},   bus.instr_args,        args);
    chk({name, "_pc"},     64'(bus.instr_pc),     64'(pc));
  endtask

  initial begin
    int g0;
    int n;
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_addr   = '0;
    fetch_busy      = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h12; mem[12'h101] = 8'h02; mem[12'h102] = 8'h34;
    mem[12'h103] = 8'h12; mem[12'h104] = 8'hCD; mem[12'h105] = 8'hAB;
    mem[12'h106] = 8'h07; mem[12'h107] = 8'h00;
    mem[12'h200] = 8'h33; mem[12'h201] = 8'h01; mem[12'h202] = 8'hEF; mem[12'h203] = 8'hBE;
    mem[12'h300] = 8'h07; mem[12'h301] = 8'h00; mem[12'h302] = 8'h08; mem[12'h303] = 8'h00;
    mem[12'h400] = 8'h09; mem[12'h401] = 8'h05;
    mem[12'h500] = 8'h21; mem[12'h501] = 8'h04;
    for (int i = 0; i < 8; i++) mem[12'h502 + 12'(i)] = 8'(8'h11 * (i + 1));

    // Reset values
    repeat (3) tick();
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_req",   64'(fetch_byte_req),  64'd0);
    chk("rst_flush", 64'(fetch_flush),     64'd0);
    chk("rst_start", 64'(fetch_start_addr), 64'd0);
    chk("rst_err",   64'(err_argc),        64'd0);
    chk_instr("rst", 8'h00, 8'h00, 64'd0, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req", 64'(fetch_byte_req), 64'd0);
    end

    // Boot at 0x100, then the following opcode at 0x106
    do_redirect(32'h100);
    wait_valid("boot_wait", 1'b0);
    chk_instr("boot", 8'h12, 8'h02, 64'h0000_0000_ABCD_1234, 32'h100);
    wait_valid("next_wait", 1'b0);
    chk_instr("next", 8'h07, 8'h00, 64'd0, 32'h106);

    // argc=0 back-to-back: exactly four bytes fetched
    do_redirect(32'h300);
    g0 = grants;
    wait_valid("z0_wait", 1'b0);
    chk_instr("z0", 8'h07, 8'h00, 64'd0, 32'h300);
    wait_valid("z1_wait", 1'b0);
    chk_instr("z1", 8'h08, 8'h00, 64'd0, 32'h302);
    chk("z_bytes", 64'(grants - g0), 64'd4);

    // Backpressure for 10 cycles, then immediate fetch after handshake
    bus.instr_ready = 1'b0;
    do_redirect(32'h100);
    wait_valid("bp_wait", 1'b0);
    g0 = grants;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_req", 64'(fetch_byte_req), 64'd0);
    end
    chk("bp_grants", 64'(grants - g0), 64'd0);
    chk_instr("bp", 8'h12, 8'h02, 64'h0000_0000_ABCD_1234, 32'h100);
    bus.instr_ready = 1'b1;
    tick();
    chk("bp_after_valid", 64'(bus.instr_valid), 64'd0);
    chk("bp_after_req",   64'(fetch_byte_req),  64'd1);

    // Four operands without and with a toggling busy fetcher
    do_redirect(32'h500);
    wait_valid("ns_wait", 1'b0);
    chk_instr("ns", 8'h21, 8'h04, 64'h8877_6655_4433_2211, 32'h500);
    do_redirect(32'h500);
    wait_valid("busy_wait", 1'b1);
    fetch_busy = 1'b0;
    chk_instr("busy", 8'h21, 8'h04, 64'h8877_6655_4433_2211, 32'h500);

    // Redirect mid-operands with stray valids around the redirect
    do_redirect(32'h500);
    g0 = grants;
    n  = 0;
    while ((grants - g0) < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_progress", 64'(grants - g0 >= 3), 64'd1);
    stray = 1'b1;
    tick();
    do_redirect(32'h200);
    tick();
    stray = 1'b0;
    wait_valid("mid_wait", 1'b0);
    chk_instr("mid", 8'h33, 8'h01, 64'h0000_0000_0000_BEEF, 32'h200);

    // argc above MAX_ARGS: sticky error, silence, cleared by redirect
    do_redirect(32'h400);
    n = 0;
    while (!err_argc && n < 50) begin
      tick();
      n++;
    end
    chk("err_set", 64'(err_argc), 64'd1);
    g0 = grants;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("err_req",   64'(fetch_byte_req),  64'd0);
      chk("err_valid", 64'(bus.instr_valid), 64'd0);
    end
    chk("err_grants", 64'(grants - g0), 64'd0);
    do_redirect(32'h200);
    chk("err_clear", 64'(err_argc), 64'd0);
    wait_valid("rec_wait", 1'b0);
    chk_instr("rec", 8'h33, 8'h01, 64'h0000_0000_0000_BEEF, 32'h200);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
